// File: rtl/tinymips_pkg.sv
// Shared TinyMIPS constants: RAM geometry, arbiter burst limit and arbiter state encoding.
package tinymips_pkg;

  localparam int unsigned AW        = 8;
  localparam int unsigned DW        = 16;
  localparam int unsigned MAX_BURST = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus between the two requesters (TinyMIPS core, loader/debug host), the arbiter and the blram.
//   req/lock/we/addr/wdata : per-port request signals
//   gnt/rvalid/rdata       : per-port responses
//   ram_we/ram_addr/ram_din/ram_dout : blram side
//   modport slave  : arbiter view
//   modport master : requester + blram view
interface ram_arbiter_if #(
  parameter int unsigned AW = tinymips_pkg::AW,
  parameter int unsigned DW = tinymips_pkg::DW
);

  logic          req0, req1;
  logic          lock0, lock1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_we, ram_addr, ram_din
  );

  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, ram_we, ram_addr, ram_din
  );

endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port blram with optional locked bursts.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : ram_arbiter_if.slave -- requester handshakes and blram signals
// Grants and the blram address/data/we are combinational so an access completes in its
// grant cycle; rvalid is registered to line up with the blram's 1-cycle read latency.
module ram_arbiter #(
  parameter int unsigned AW        = tinymips_pkg::AW,
  parameter int unsigned DW        = tinymips_pkg::DW,
  parameter int unsigned MAX_BURST = tinymips_pkg::MAX_BURST
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  import tinymips_pkg::*;

  localparam int unsigned     CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e       r_state;
  logic             r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rvalid0;
  logic             r_rvalid1;

  logic             w_keep;
  logic             w_pri;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_we;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_din;

  // Grant decision: keep a locked owner unless it is capped with the other port waiting;
  // otherwise arbitrate, giving the non-owner priority when releasing.
  always_comb begin
    w_keep = 1'b0;
    w_pri  = r_ptr;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      OWN0: begin
        w_keep = bus.req0 & bus.lock0 & ~((r_cnt == CNT_MAX) & bus.req1);
        w_pri  = 1'b1;
      end
      OWN1: begin
        w_keep = bus.req1 & bus.lock1 & ~((r_cnt == CNT_MAX) & bus.req0);
        w_pri  = 1'b0;
      end
      default: ;
    endcase
    if (w_keep) begin
      w_gnt0 = (r_state == OWN0);
      w_gnt1 = (r_state == OWN1);
    end else if (bus.req0 & bus.req1) begin
      w_gnt0 = ~w_pri;
      w_gnt1 = w_pri;
    end else begin
      w_gnt0 = bus.req0;
      w_gnt1 = bus.req1;
    end
    // Everything facing the requesters and the blram is quiet while in reset.
    if (!rst) begin
      w_keep = 1'b0;
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  // Route the granted port to the blram; zeros when idle.
  always_comb begin
    w_we   = 1'b0;
    w_addr = '0;
    w_din  = '0;
    if (w_gnt0) begin
      w_we   = bus.we0;
      w_addr = bus.addr0;
      w_din  = bus.wdata0;
    end else if (w_gnt1) begin
      w_we   = bus.we1;
      w_addr = bus.addr1;
      w_din  = bus.wdata1;
    end
  end

  // Ownership state, round-robin pointer, burst counter and read-valid pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_ptr     <= 1'b0;
      r_cnt     <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~bus.we0;
      r_rvalid1 <= w_gnt1 & ~bus.we1;
      if (w_keep) begin
        if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end else if (w_gnt0 | w_gnt1) begin
        r_ptr <= w_gnt0;
        if (w_gnt0 & bus.lock0) begin
          r_state <= OWN0;
          r_cnt   <= CNT_ONE;
        end else if (w_gnt1 & bus.lock1) begin
          r_state <= OWN1;
          r_cnt   <= CNT_ONE;
        end else begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      end else begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end
    end
  end

  assign bus.gnt0     = w_gnt0;
  assign bus.gnt1     = w_gnt1;
  assign bus.ram_we   = w_we;
  assign bus.ram_addr = w_addr;
  assign bus.ram_din  = w_din;
  assign bus.rvalid0  = r_rvalid0;
  assign bus.rvalid1  = r_rvalid1;
  assign bus.rdata    = bus.ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a blram model, a behavioural arbitration model
// (owner / burst length / pointer as plain integers), directed scenarios and random traffic.
module tb_ram_arbiter;

  import tinymips_pkg::*;

  localparam int MB    = MAX_BURST;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [DW-1:0] init_val(input int i);
    logic [31:0] v;
    v = i * 32'h9E37 + 32'h55;
    return (i == 16'h10) ? 16'hBEEF : v[DW-1:0];
  endfunction

  // blram: synchronous read, 1-cycle latency, read-before-write
  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = init_val(i);
    bus.ram_dout = '0;
    forever begin
      @(posedge clk);
      bus.ram_dout <= mem[bus.ram_addr];
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    end
  end

  // Behavioural model: owner (-1 none), length of current burst, round-robin pointer.
  int            m_owner;
  int            m_burst;
  int            m_ptr;
  bit            m_rv0, m_rv1;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] ref_mem [DEPTH];

  function automatic int model_winner(output bit keep);
    bit rq[2];
    bit lk[2];
    rq[0] = bus.req0;  rq[1] = bus.req1;
    lk[0] = bus.lock0; lk[1] = bus.lock1;
    keep = 1'b0;
    if (m_owner >= 0 && rq[m_owner] && lk[m_owner] &&
        !(m_burst == MB && rq[1-m_owner])) begin
      keep = 1'b1;
      return m_owner;
    end
    if (rq[0] && rq[1]) return (m_owner >= 0) ? 1 - m_owner : m_ptr;
    if (rq[0]) return 0;
    if (rq[1]) return 1;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare();
    bit            k;
    int            w;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    if (!rst) begin
      check("rst_gnt0", bus.gnt0, 0);
      check("rst_gnt1", bus.gnt1, 0);
      check("rst_rvalid0", bus.rvalid0, 0);
      check("rst_rvalid1", bus.rvalid1, 0);
      check("rst_ram_we", bus.ram_we, 0);
      check("rst_ram_addr", bus.ram_addr, 0);
      check("rst_ram_din", bus.ram_din, 0);
    end else begin
      w = model_winner(k);
      e_we = 1'b0; e_addr = '0; e_din = '0;
      if (w == 0) begin e_we = bus.we0; e_addr = bus.addr0; e_din = bus.wdata0; end
      if (w == 1) begin e_we = bus.we1; e_addr = bus.addr1; e_din = bus.wdata1; end
      check("gnt0", bus.gnt0, 32'(w == 0));
      check("gnt1", bus.gnt1, 32'(w == 1));
      check("ram_we", bus.ram_we, e_we);
      check("ram_addr", bus.ram_addr, e_addr);
      check("ram_din", bus.ram_din, e_din);
      check("rvalid0", bus.rvalid0, m_rv0);
      check("rvalid1", bus.rvalid1, m_rv1);
      if (m_rv0 || m_rv1) check("rdata", bus.rdata, m_rdata);
    end
  endtask

  task automatic model_step();
    bit k;
    int w;
    bit lk[2];
    if (!rst) begin
      m_owner = -1; m_burst = 0; m_ptr = 0; m_rv0 = 0; m_rv1 = 0;
      return;
    end
    lk[0] = bus.lock0; lk[1] = bus.lock1;
    w = model_winner(k);
    m_rv0 = (w == 0) && !bus.we0;
    m_rv1 = (w == 1) && !bus.we1;
    if (w == 0) begin
      if (bus.we0) ref_mem[bus.addr0] = bus.wdata0; else m_rdata = ref_mem[bus.addr0];
    end
    if (w == 1) begin
      if (bus.we1) ref_mem[bus.addr1] = bus.wdata1; else m_rdata = ref_mem[bus.addr1];
    end
    if (w < 0) begin
      m_owner = -1; m_burst = 0;
    end else if (k) begin
      m_burst = (m_burst < MB) ? m_burst + 1 : MB;
    end else begin
      m_ptr = 1 - w;
      if (lk[w]) begin m_owner = w; m_burst = 1; end
      else begin m_owner = -1; m_burst = 0; end
    end
  endtask

  task automatic half();
    @(negedge clk);
    compare();
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clr();
    bus.req0 = 0; bus.req1 = 0; bus.lock0 = 0; bus.lock1 = 0;
    bus.we0 = 0; bus.we1 = 0; bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic do_reset();
    clr();
    rst = 0;
    half();
    adv();
    rst = 1;
  endtask

  bit hold0, hold1;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    m_owner = -1; m_burst = 0; m_ptr = 0; m_rv0 = 0; m_rv1 = 0; m_rdata = '0;
    clr();
    rst = 0;
    half();
    check("lit_reset_gnt0", bus.gnt0, 0);
    check("lit_reset_rvalid0", bus.rvalid0, 0);
    adv();
    rst = 1;

    // single read of a preloaded word
    bus.req0 = 1; bus.addr0 = 8'h10;
    half();
    check("lit_read_gnt0", bus.gnt0, 1);
    adv();
    clr();
    half();
    check("lit_read_rvalid0", bus.rvalid0, 1);
    check("lit_read_rdata", bus.rdata, 16'hBEEF);
    check("lit_read_rvalid1", bus.rvalid1, 0);
    adv();

    // unlocked contention alternates
    do_reset();
    bus.req0 = 1; bus.req1 = 1; bus.addr0 = 8'h21; bus.addr1 = 8'h42;
    for (int i = 0; i < 4; i++) begin
      half();
      check("lit_rr_gnt1", bus.gnt1, 32'(i % 2));
      check("lit_rr_addr", bus.ram_addr, (i % 2) ? 32'h42 : 32'h21);
      adv();
    end

    // burst cap: port 1 joins on cycle 2, gets cycle 4, then pointer favours 0
    do_reset();
    bus.req0 = 1; bus.lock0 = 1; bus.addr0 = 8'h03;
    for (int c = 0; c < 6; c++) begin
      if (c >= 2) begin bus.req1 = 1; bus.addr1 = 8'h04; end
      half();
      check("lit_cap_gnt0", bus.gnt0, 32'(c != 4));
      check("lit_cap_gnt1", bus.gnt1, 32'(c == 4));
      adv();
    end

    // write on port 1, read back on port 0
    clr();
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'hFF; bus.wdata1 = 16'h1234;
    half();
    check("lit_wr_gnt1", bus.gnt1, 1);
    check("lit_wr_ram_we", bus.ram_we, 1);
    check("lit_wr_ram_din", bus.ram_din, 16'h1234);
    adv();
    clr();
    bus.req0 = 1; bus.addr0 = 8'hFF;
    half();
    check("lit_rb_gnt0", bus.gnt0, 1);
    check("lit_rb_rvalid1", bus.rvalid1, 0);
    adv();
    clr();
    half();
    check("lit_rb_rvalid0", bus.rvalid0, 1);
    check("lit_rb_rdata", bus.rdata, 16'h1234);
    check("lit_rb_rvalid1b", bus.rvalid1, 0);
    adv();

    // reset in the middle of a port-1 locked read burst
    do_reset();
    bus.req1 = 1; bus.lock1 = 1; bus.addr1 = 8'h10;
    half();
    check("lit_mid_gnt1", bus.gnt1, 1);
    adv();
    #2;
    rst = 0;
    #1;
    check("lit_mid_rst_gnt1", bus.gnt1, 0);
    check("lit_mid_rst_rvalid1", bus.rvalid1, 0);
    check("lit_mid_rst_ram_addr", bus.ram_addr, 0);
    half();
    adv();
    half();
    adv();
    clr();
    bus.req0 = 1; bus.req1 = 1;
    rst = 1;
    half();
    check("lit_post_rst_gnt0", bus.gnt0, 1);
    check("lit_post_rst_gnt1", bus.gnt1, 0);
    adv();

    // lock drop hands over in the same cycle, then IDLE with pointer at 0
    do_reset();
    bus.req0 = 1; bus.lock0 = 1;
    half();
    adv();
    bus.lock0 = 0; bus.req1 = 1;
    half();
    check("lit_rel_gnt1", bus.gnt1, 1);
    check("lit_rel_gnt0", bus.gnt0, 0);
    adv();
    half();
    check("lit_rel_idle_gnt0", bus.gnt0, 1);
    adv();

    // uncontended lock held indefinitely; saturated burst yields at once to a newcomer
    do_reset();
    bus.req0 = 1; bus.lock0 = 1;
    for (int c = 0; c < 8; c++) begin
      half();
      check("lit_hold_gnt0", bus.gnt0, 1);
      adv();
    end
    bus.req1 = 1;
    half();
    check("lit_sat_gnt1", bus.gnt1, 1);
    adv();

    // random traffic; an ungranted requester holds its request
    clr();
    hold0 = 0; hold1 = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold0) begin
        bus.req0   = ($urandom_range(0, 2) != 0);
        bus.we0    = ($urandom_range(0, 2) == 0);
        bus.addr0  = AW'($urandom_range(0, 15));
        bus.wdata0 = DW'($urandom);
      end
      if (!hold1) begin
        bus.req1   = ($urandom_range(0, 2) != 0);
        bus.we1    = ($urandom_range(0, 2) == 0);
        bus.addr1  = AW'($urandom_range(0, 15));
        bus.wdata1 = DW'($urandom);
      end
      bus.lock0 = ($urandom_range(0, 3) != 0);
      bus.lock1 = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) != 0);
      half();
      hold0 = bus.req0 && !bus.gnt0;
      hold1 = bus.req1 && !bus.gnt1;
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
